// File: rtl/encoder_8to3_reg_if.sv
// rtl/encoder_8to3_reg_if.sv - handshake, payload and error-counter signals of the registered 8-to-3 encoder
//
// Purpose: bundles every non-clock/reset signal of encoder_8to3_reg.
//   slave  modport: the encoder itself (consumes y, produces a/b/c/zero/multi)
//   master modport: the surrounding logic that feeds words and takes results
// Signals:
//   in_valid/in_ready/y              input word handshake
//   out_valid/out_ready/a/b/c        result handshake and encoded index (a = MSB)
//   zero/multi                       accepted word was 0 / had more than one bit set
//   clr_cnt/err_cnt                  synchronous clear and saturating error count
interface encoder_8to3_reg_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       y;
    logic             out_valid;
    logic             out_ready;
    logic             a;
    logic             b;
    logic             c;
    logic             zero;
    logic             multi;
    logic             clr_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid,
        input  y,
        input  out_ready,
        input  clr_cnt,
        output in_ready,
        output out_valid,
        output a,
        output b,
        output c,
        output zero,
        output multi,
        output err_cnt
    );

    modport master (
        output in_valid,
        output y,
        output out_ready,
        output clr_cnt,
        input  in_ready,
        input  out_valid,
        input  a,
        input  b,
        input  c,
        input  zero,
        input  multi,
        input  err_cnt
    );
endinterface

// File: rtl/encoder_8to3_reg.sv
// rtl/encoder_8to3_reg.sv - registered 8-to-3 one-hot encoder with valid/ready handshake and error counter
//
// Purpose: encodes an 8-bit one-hot word into its 3-bit index {a,b,c} through a
//   single-entry output register. Non-one-hot words (zero or multi-hot) are
//   flagged and counted in a saturating counter.
// Parameters:
//   PRIORITY_HIGH  1: highest set bit wins on a multi-hot word, 0: lowest set bit wins
//   CNT_W          width of err_cnt (must match the interface CNT_W)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    encoder_8to3_reg_if.slave: input/result handshakes, payload, error counter
module encoder_8to3_reg #(
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    encoder_8to3_reg_if.slave     bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_idx;
    logic             r_zero;
    logic             r_multi;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic [2:0]       w_idx;
    logic             w_zero;
    logic             w_multi;
    logic             w_err;

    // The slot is free when empty, or when the held result leaves on this
    // same edge; this gives one word per cycle under continuous out_ready.
    assign w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Priority encode: the loop direction makes the last matching bit win,
    // so ascending order selects the highest set bit and descending the lowest.
    always_comb begin
        w_idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.y[i]) begin
                    w_idx = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (bus.y[i]) begin
                    w_idx = 3'(i);
                end
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_zero  = (bus.y == 8'h00);
    assign w_multi = ((bus.y & (bus.y - 8'd1)) != 8'h00);
    assign w_err   = w_accept && (w_zero || w_multi);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !bus.in_valid) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload only moves on an accept edge; it keeps its last value while
    // empty so downstream never sees a spurious change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 3'd0;
            r_zero  <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_zero  <= w_zero;
            r_multi <= w_multi;
        end
    end

    // Clear has priority over a coincident error; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.a         = r_idx[2];
    assign bus.b         = r_idx[1];
    assign bus.c         = r_idx[0];
    assign bus.zero      = r_zero;
    assign bus.multi     = r_multi;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_encoder_8to3_reg.sv
// tb/tb_encoder_8to3_reg.sv - self-checking bench for encoder_8to3_reg (high and low priority instances)
module tb_encoder_8to3_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] y_s;
    logic       out_ready;
    logic       clr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    encoder_8to3_reg_if #(.CNT_W(8)) if_hi ();
    encoder_8to3_reg_if #(.CNT_W(2)) if_lo ();

    assign if_hi.in_valid  = in_valid;
    assign if_hi.y         = y_s;
    assign if_hi.out_ready = out_ready;
    assign if_hi.clr_cnt   = clr_cnt;
    assign if_lo.in_valid  = in_valid;
    assign if_lo.y         = y_s;
    assign if_lo.out_ready = out_ready;
    assign if_lo.clr_cnt   = clr_cnt;

    encoder_8to3_reg #(.PRIORITY_HIGH(1'b1), .CNT_W(8)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_hi)
    );

    encoder_8to3_reg #(.PRIORITY_HIGH(1'b0), .CNT_W(2)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the index is a plain logarithm of the highest / lowest set bit.
    bit m_valid;
    int m_idx_hi;
    int m_idx_lo;
    bit m_zero;
    bit m_multi;
    int m_cnt_hi;
    int m_cnt_lo;

    function automatic int enc_hi(int v);
        return (v == 0) ? 0 : $clog2(v + 1) - 1;
    endfunction

    function automatic int enc_lo(int v);
        return (v == 0) ? 0 : $clog2(v & (-v));
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_idx_hi = 0;
        m_idx_lo = 0;
        m_zero   = 0;
        m_multi  = 0;
        m_cnt_hi = 0;
        m_cnt_lo = 0;
    endtask

    task automatic check_all(string tag);
        chk({tag, " valid_hi"}, int'(if_hi.out_valid), int'(m_valid));
        chk({tag, " valid_lo"}, int'(if_lo.out_valid), int'(m_valid));
        chk({tag, " idx_hi"}, int'({if_hi.a, if_hi.b, if_hi.c}), m_idx_hi);
        chk({tag, " idx_lo"}, int'({if_lo.a, if_lo.b, if_lo.c}), m_idx_lo);
        chk({tag, " zero"}, int'(if_hi.zero), int'(m_zero));
        chk({tag, " multi"}, int'(if_lo.multi), int'(m_multi));
        chk({tag, " cnt_hi"}, int'(if_hi.err_cnt), m_cnt_hi);
        chk({tag, " cnt_lo"}, int'(if_lo.err_cnt), m_cnt_lo);
    endtask

    // Entered just after a falling edge; returns on the next falling edge.
    task automatic step(string tag, input bit iv, input logic [7:0] yy, input bit ordy, input bit clr);
        bit acc;
        bit err;
        in_valid  = iv;
        y_s       = yy;
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        chk({tag, " in_ready_hi"}, int'(if_hi.in_ready), int'(!m_valid || ordy));
        chk({tag, " in_ready_lo"}, int'(if_lo.in_ready), int'(!m_valid || ordy));
        @(posedge clk);
        acc = iv && (!m_valid || ordy);
        err = acc && ((yy == 8'h00) || ($countones(yy) > 1));
        if (acc) begin
            m_valid  = 1;
            m_idx_hi = enc_hi(int'(yy));
            m_idx_lo = enc_lo(int'(yy));
            m_zero   = (yy == 8'h00);
            m_multi  = ($countones(yy) > 1);
        end else if (ordy) begin
            m_valid = 0;
        end
        if (clr) begin
            m_cnt_hi = 0;
            m_cnt_lo = 0;
        end else if (err) begin
            m_cnt_hi = (m_cnt_hi < 255) ? m_cnt_hi + 1 : 255;
            m_cnt_lo = (m_cnt_lo < 3) ? m_cnt_lo + 1 : 3;
        end
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] y;
        int         idx_hi;
        int         idx_lo;
        bit         zero;
        bit         multi;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{8'h01, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{8'h02, 1, 1, 1'b0, 1'b0};
        vecs[2]  = '{8'h04, 2, 2, 1'b0, 1'b0};
        vecs[3]  = '{8'h08, 3, 3, 1'b0, 1'b0};
        vecs[4]  = '{8'h10, 4, 4, 1'b0, 1'b0};
        vecs[5]  = '{8'h20, 5, 5, 1'b0, 1'b0};
        vecs[6]  = '{8'h40, 6, 6, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 7, 7, 1'b0, 1'b0};
        vecs[8]  = '{8'hA0, 7, 5, 1'b0, 1'b1};
        vecs[9]  = '{8'h06, 2, 1, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 0, 0, 1'b1, 1'b0};
        vecs[11] = '{8'hFF, 7, 0, 1'b0, 1'b1};
        vecs[12] = '{8'h81, 7, 0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        y_s       = 8'h00;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Table: one word per cycle, results compared against fixed expectations.
        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), 1'b1, vecs[i].y, 1'b1, 1'b0);
            chk($sformatf("vec%0d tbl_idx_hi", i), int'({if_hi.a, if_hi.b, if_hi.c}), vecs[i].idx_hi);
            chk($sformatf("vec%0d tbl_idx_lo", i), int'({if_lo.a, if_lo.b, if_lo.c}), vecs[i].idx_lo);
            chk($sformatf("vec%0d tbl_zero", i), int'(if_hi.zero), int'(vecs[i].zero));
            chk($sformatf("vec%0d tbl_multi", i), int'(if_hi.multi), int'(vecs[i].multi));
            if (i == 7) begin
                chk("onehot cnt_hi stays 0", int'(if_hi.err_cnt), 0);
            end
        end
        step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: held result stays put while the consumer stalls.
        step("bp_accept", 1'b1, 8'h08, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("bp_stall%0d", k), 1'b1, 8'h10, 1'b0, 1'b0);
            chk("bp idx stable", int'({if_hi.a, if_hi.b, if_hi.c}), 3);
            chk("bp in_ready low", int'(if_hi.in_ready), 0);
        end
        step("bp_release", 1'b1, 8'h40, 1'b1, 1'b0);
        chk("bp new idx", int'({if_lo.a, if_lo.b, if_lo.c}), 6);
        step("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp empty", int'(if_hi.out_valid), 0);

        // Saturation of the narrow counter and clear winning over an error.
        step("sat_clr", 1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("sat_err%0d", k), 1'b1, (k % 2 == 0) ? 8'h00 : 8'h0C, 1'b1, 1'b0);
        end
        chk("sat cnt_lo", int'(if_lo.err_cnt), 3);
        chk("sat cnt_hi", int'(if_hi.err_cnt), 5);
        step("clr_vs_err", 1'b1, 8'h00, 1'b1, 1'b1);
        chk("clr wins lo", int'(if_lo.err_cnt), 0);
        chk("clr wins hi", int'(if_hi.err_cnt), 0);

        // Asynchronous reset while holding a stalled result.
        step("rst_fill", 1'b1, 8'h30, 1'b0, 1'b0);
        step("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst valid", int'(if_hi.out_valid), 0);
        chk("async rst cnt_hi", int'(if_hi.err_cnt), 0);
        chk("async rst cnt_lo", int'(if_lo.err_cnt), 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1'b1, 8'h01, 1'b1, 1'b0);
        chk("post rst idx", int'({if_hi.a, if_hi.b, if_hi.c}), 0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] ry;
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       ry = 8'h00;
                1, 2:    ry = 8'(1 << $urandom_range(0, 7));
                default: ry = 8'($urandom_range(0, 255));
            endcase
            step("rand", 1'($urandom_range(0, 3) != 0), ry,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
